// File: rtl/adc_capture_ctrl.sv
// Triggered capture sequencer for the ADC sample ring buffer: fills a pre-trigger
// window, waits for a software or level-crossing trigger, records a post-trigger window.
module adc_capture_ctrl #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int PTR_BITS     = 10
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    arm,
  input  logic                    abort,
  input  logic                    sw_trig,
  input  logic                    trig_en,
  input  logic                    trig_rise,
  input  logic [SAMPLE_WIDTH-1:0] trig_level,
  input  logic [PTR_BITS-1:0]     pre_cnt,
  input  logic [PTR_BITS-1:0]     post_cnt,
  input  logic                    smp_valid,
  input  logic [SAMPLE_WIDTH-1:0] smp_data,
  output logic                    ram_we,
  output logic [PTR_BITS-1:0]     ram_waddr,
  output logic [SAMPLE_WIDTH-1:0] ram_wdata,
  output logic [2:0]              state,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [PTR_BITS-1:0]     trig_addr,
  output logic [PTR_BITS-1:0]     start_addr
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [PTR_BITS-1:0] PTR_ONE  = {{(PTR_BITS-1){1'b0}}, 1'b1};
  localparam logic [PTR_BITS:0]   WIN_ONE  = {{PTR_BITS{1'b0}}, 1'b1};
  localparam logic [PTR_BITS:0]   WIN_MAX  = {1'b1, {PTR_BITS{1'b0}}};

  state_e                           state_q, state_d;
  logic [PTR_BITS-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]              pre_q, pre_d;
  logic [PTR_BITS-1:0]              post_q, post_d;
  logic [PTR_BITS-1:0]              cnt_q, cnt_d;
  logic                             pend_q, pend_d;
  logic                             prev_vld_q, prev_vld_d;
  logic signed [SAMPLE_WIDTH-1:0]   prev_q, prev_d;
  logic                             ram_we_d;
  logic [PTR_BITS-1:0]              ram_waddr_d;
  logic [SAMPLE_WIDTH-1:0]          ram_wdata_d;
  logic                             cfg_err_d;
  logic [PTR_BITS-1:0]              trig_addr_d, start_addr_d;
  logic                             busy_d, done_d;

  // Window length is evaluated one bit wider so a full-ring window (2^PTR_BITS) is legal.
  logic [PTR_BITS:0]                win_len;
  logic                             cfg_bad;
  logic signed [SAMPLE_WIDTH-1:0]   cur_s, lvl_s;
  logic                             rise_x, fall_x, level_hit;
  logic                             capturing, wr_fire;
  logic [PTR_BITS-1:0]              cnt_inc;

  assign win_len   = {1'b0, pre_cnt} + {1'b0, post_cnt} + WIN_ONE;
  assign cfg_bad   = (win_len > WIN_MAX);

  assign cur_s     = $signed(smp_data);
  assign lvl_s     = $signed(trig_level);
  assign rise_x    = (prev_q <  lvl_s) && (lvl_s <= cur_s);
  assign fall_x    = (prev_q >= lvl_s) && (lvl_s >  cur_s);
  assign level_hit = trig_en && prev_vld_q && (trig_rise ? rise_x : fall_x);

  assign capturing = (state_q == S_FILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign wr_fire   = capturing && smp_valid && !abort;
  assign cnt_inc   = cnt_q + PTR_ONE;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves a latch.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pre_d        = pre_q;
    post_d       = post_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    prev_vld_d   = prev_vld_q;
    prev_d       = prev_q;
    ram_we_d     = 1'b0;
    ram_waddr_d  = ram_waddr;
    ram_wdata_d  = ram_wdata;
    cfg_err_d    = 1'b0;
    trig_addr_d  = trig_addr;
    start_addr_d = start_addr;

    if (abort) begin
      // Abort beats everything, including a sample or arm in the same cycle.
      if (state_q != S_IDLE) begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
      end
    end else begin
      if (wr_fire) begin
        ram_we_d    = 1'b1;
        ram_waddr_d = wr_ptr_q;
        ram_wdata_d = smp_data;
        wr_ptr_d    = wr_ptr_q + PTR_ONE;
        prev_d      = cur_s;
        prev_vld_d  = 1'b1;
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            if (cfg_bad) begin
              cfg_err_d = 1'b1;
            end else begin
              wr_ptr_d   = '0;
              pre_d      = pre_cnt;
              post_d     = post_cnt;
              cnt_d      = '0;
              pend_d     = 1'b0;
              prev_vld_d = 1'b0;
              state_d    = (pre_cnt == '0) ? S_ARMED : S_FILL;
            end
          end
        end

        S_FILL: begin
          if (smp_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pre_q) begin
              cnt_d   = '0;
              state_d = S_ARMED;
            end
          end
        end

        S_ARMED: begin
          if (sw_trig) pend_d = 1'b1;
          if (smp_valid && (pend_q || sw_trig || level_hit)) begin
            trig_addr_d  = wr_ptr_q;
            start_addr_d = wr_ptr_q - pre_q;
            pend_d       = 1'b0;
            cnt_d        = '0;
            state_d      = (post_q == '0) ? S_DONE : S_POST;
          end
        end

        S_POST: begin
          if (smp_valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == post_q) state_d = S_DONE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_FILL) || (state_d == S_ARMED) || (state_d == S_POST);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
    if (wb_rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      pre_q      <= '0;
      post_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      prev_vld_q <= 1'b0;
      prev_q     <= '0;
      ram_we     <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      cfg_err    <= 1'b0;
      trig_addr  <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      prev_vld_q <= prev_vld_d;
      prev_q     <= prev_d;
      ram_we     <= ram_we_d;
      ram_waddr  <= ram_waddr_d;
      ram_wdata  <= ram_wdata_d;
      cfg_err    <= cfg_err_d;
      trig_addr  <= trig_addr_d;
      start_addr <= start_addr_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: table of capture windows plus hand-written corner
// sequences; every RAM write is matched against a queue of expected writes.
module tb_adc_capture_ctrl;

  localparam int SW = 16;
  localparam int PB = 10;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i;
  logic          arm, abort, sw_trig, trig_en, trig_rise;
  logic [SW-1:0] trig_level;
  logic [PB-1:0] pre_cnt, post_cnt;
  logic          smp_valid;
  logic [SW-1:0] smp_data;
  logic          ram_we;
  logic [PB-1:0] ram_waddr;
  logic [SW-1:0] ram_wdata;
  logic [2:0]    state;
  logic          busy, done, cfg_err;
  logic [PB-1:0] trig_addr, start_addr;

  adc_capture_ctrl #(.SAMPLE_WIDTH(SW), .PTR_BITS(PB)) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .arm       (arm),
    .abort     (abort),
    .sw_trig   (sw_trig),
    .trig_en   (trig_en),
    .trig_rise (trig_rise),
    .trig_level(trig_level),
    .pre_cnt   (pre_cnt),
    .post_cnt  (post_cnt),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .trig_addr (trig_addr),
    .start_addr(start_addr)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int pre;
    int post;
    int trig;
    bit err;
    int ta;
    int sa;
    int last;
  } vec_t;

  typedef struct {
    logic [PB-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  vec_t vecs[7];
  int   exp_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int addr, input logic [SW-1:0] d);
    wr_t e;
    e.addr = addr[PB-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every write the DUT makes must be the next one the stimulus expected.
  always @(negedge wb_clk_i) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", ram_waddr, ram_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(ram_waddr), 32'(e.addr));
        check("wr_data", 32'(ram_wdata), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [SW-1:0] d, input bit st);
    smp_valid = v;
    smp_data  = d;
    sw_trig   = st;
    tick();
    smp_valid = 1'b0;
    sw_trig   = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [SW-1:0] d, input bit st);
    expect_wr(addr, d);
    drive(1'b1, d, st);
  endtask

  task automatic do_arm(input int pre, input int post);
    pre_cnt  = pre[PB-1:0];
    post_cnt = post[PB-1:0];
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  initial begin
    int            t;
    logic [SW-1:0] d;
    vec_t          v;

    vecs[0] = '{pre: 4,    post: 3,   trig: 10,   err: 0, ta: 10,   sa: 6,    last: 13};
    vecs[1] = '{pre: 0,    post: 2,   trig: 0,    err: 0, ta: 0,    sa: 0,    last: 2};
    vecs[2] = '{pre: 3,    post: 0,   trig: 5,    err: 0, ta: 5,    sa: 2,    last: 5};
    vecs[3] = '{pre: 600,  post: 500, trig: 0,    err: 1, ta: 0,    sa: 0,    last: 0};
    vecs[4] = '{pre: 8,    post: 5,   trig: 1030, err: 0, ta: 6,    sa: 1022, last: 11};
    vecs[5] = '{pre: 1001, post: 23,  trig: 0,    err: 1, ta: 0,    sa: 0,    last: 0};
    vecs[6] = '{pre: 1000, post: 23,  trig: 1000, err: 0, ta: 1000, sa: 0,    last: 1023};

    wb_rst_i = 1'b1; arm = 1'b0; abort = 1'b0; sw_trig = 1'b0;
    trig_en = 1'b0; trig_rise = 1'b0; trig_level = '0;
    pre_cnt = '0; post_cnt = '0; smp_valid = 1'b0; smp_data = '0;
    repeat (3) tick();
    wb_rst_i = 1'b0;

    check("rst_ram_we",     32'(ram_we),     0);
    check("rst_ram_waddr",  32'(ram_waddr),  0);
    check("rst_ram_wdata",  32'(ram_wdata),  0);
    check("rst_state",      32'(state),      0);
    check("rst_busy",       32'(busy),       0);
    check("rst_done",       32'(done),       0);
    check("rst_cfg_err",    32'(cfg_err),    0);
    check("rst_trig_addr",  32'(trig_addr),  0);
    check("rst_start_addr", 32'(start_addr), 0);
    exp_state = 0;

    // Table: software-triggered capture windows, including wrap and limit cases.
    for (int r = 0; r < 7; r++) begin
      v = vecs[r];
      do_arm(v.pre, v.post);
      if (v.err) begin
        check($sformatf("r%0d_cfg_err_hi", r), 32'(cfg_err), 1);
        check($sformatf("r%0d_err_state", r), 32'(state), 32'(exp_state));
        drive(1'b0, '0, 1'b0);
        check($sformatf("r%0d_cfg_err_lo", r), 32'(cfg_err), 0);
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h1234, 1'b0);
        continue;
      end
      check($sformatf("r%0d_arm_state", r), 32'(state), (v.pre == 0) ? 2 : 1);
      check($sformatf("r%0d_arm_busy", r), 32'(busy), 1);
      check($sformatf("r%0d_arm_done", r), 32'(done), 0);
      for (int i = 0; i <= v.trig + v.post; i++) begin
        t = i * 7 + r * 1000;
        d = t[SW-1:0];
        wr(i % 1024, d, i == v.trig);
        if (v.pre > 0 && i == v.trig - 1)
          check($sformatf("r%0d_armed_before_trig", r), 32'(state), 2);
        if (i == v.trig) begin
          check($sformatf("r%0d_trig_addr", r), 32'(trig_addr), 32'(v.ta));
          check($sformatf("r%0d_start_addr", r), 32'(start_addr), 32'(v.sa));
          check($sformatf("r%0d_trig_state", r), 32'(state), (v.post == 0) ? 4 : 3);
        end
      end
      check($sformatf("r%0d_last_we", r), 32'(ram_we), 1);
      check($sformatf("r%0d_last_done", r), 32'(done), 1);
      check($sformatf("r%0d_last_addr", r), 32'(ram_waddr), 32'(v.last));
      for (int i = 0; i < 3; i++) drive(1'b1, 16'h5a5a, 1'b0);
      check($sformatf("r%0d_hold_state", r), 32'(state), 4);
      check($sformatf("r%0d_hold_busy", r), 32'(busy), 0);
      check($sformatf("r%0d_hold_trig", r), 32'(trig_addr), 32'(v.ta));
      check($sformatf("r%0d_hold_start", r), 32'(start_addr), 32'(v.sa));
      exp_state = 4;
    end

    // Rising level crossing through 0.
    trig_en = 1'b1; trig_rise = 1'b1; trig_level = 16'h0000;
    do_arm(2, 1);
    wr(0, 16'hFFFD, 1'b0);
    wr(1, 16'hFFFE, 1'b0);
    check("rise_armed", 32'(state), 2);
    wr(2, 16'hFFFF, 1'b0);
    check("rise_no_cross", 32'(state), 2);
    wr(3, 16'h0001, 1'b0);
    check("rise_trig_addr", 32'(trig_addr), 3);
    check("rise_start_addr", 32'(start_addr), 1);
    check("rise_state_post", 32'(state), 3);
    wr(4, 16'h0005, 1'b0);
    check("rise_done", 32'(done), 1);

    // Falling crossing: landing exactly on the level does not count.
    trig_rise = 1'b0;
    do_arm(1, 0);
    wr(0, 16'h0001, 1'b0);
    wr(1, 16'h0000, 1'b0);
    check("fall_at_level", 32'(state), 2);
    wr(2, 16'hFFFF, 1'b0);
    check("fall_trig_addr", 32'(trig_addr), 2);
    check("fall_start_addr", 32'(start_addr), 1);
    check("fall_done_same_write", 32'(done & ram_we), 1);
    trig_en = 1'b0;

    // sw_trig inside FILL is dropped; a lone sw_trig in ARMED pends for the next sample.
    do_arm(4, 2);
    wr(0, 16'h0100, 1'b1);
    check("fill_trig_dropped", 32'(state), 1);
    wr(1, 16'h0101, 1'b0);
    wr(2, 16'h0102, 1'b1);
    wr(3, 16'h0103, 1'b0);
    check("fill_to_armed", 32'(state), 2);
    for (int i = 4; i < 7; i++) wr(i, 16'h0100 + 16'(i), 1'b0);
    check("armed_holds", 32'(state), 2);
    drive(1'b0, '0, 1'b1);
    check("pend_no_write", 32'(ram_we), 0);
    check("pend_still_armed", 32'(state), 2);
    wr(7, 16'h0107, 1'b0);
    check("pend_trig_addr", 32'(trig_addr), 7);
    check("pend_start_addr", 32'(start_addr), 3);
    wr(8, 16'h0108, 1'b0);
    wr(9, 16'h0109, 1'b0);
    check("pend_done", 32'(done), 1);

    // Abort during POST together with arm and a sample.
    do_arm(2, 10);
    wr(0, 16'h0200, 1'b0);
    wr(1, 16'h0201, 1'b0);
    wr(2, 16'h0202, 1'b1);
    check("abort_in_post", 32'(state), 3);
    wr(3, 16'h0203, 1'b0);
    wr(4, 16'h0204, 1'b0);
    abort = 1'b1; arm = 1'b1; smp_valid = 1'b1; smp_data = 16'h0205;
    pre_cnt = 10'd1; post_cnt = 10'd1;
    tick();
    abort = 1'b0; arm = 1'b0; smp_valid = 1'b0;
    check("abort_state", 32'(state), 0);
    check("abort_we", 32'(ram_we), 0);
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    drive(1'b1, 16'h0206, 1'b0);
    check("abort_arm_dropped", 32'(state), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_noop", 32'(state), 0);

    // Rejected arm from IDLE.
    do_arm(600, 500);
    check("idle_cfg_err", 32'(cfg_err), 1);
    check("idle_cfg_state", 32'(state), 0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'h0300, 1'b0);
    check("idle_cfg_err_lo", 32'(cfg_err), 0);

    // Reset mid-capture drops the in-flight sample and clears everything.
    do_arm(2, 5);
    check("rst2_arm_state", 32'(state), 1);
    wr(0, 16'h0400, 1'b0);
    wr(1, 16'h0401, 1'b0);
    wb_rst_i = 1'b1; smp_valid = 1'b1; smp_data = 16'h0402;
    tick();
    smp_valid = 1'b0;
    check("rst2_we", 32'(ram_we), 0);
    check("rst2_state", 32'(state), 0);
    check("rst2_busy", 32'(busy), 0);
    check("rst2_trig_addr", 32'(trig_addr), 0);
    check("rst2_waddr", 32'(ram_waddr), 0);
    check("rst2_wdata", 32'(ram_wdata), 0);
    wb_rst_i = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_capture_ctrl.md
# adc_capture_ctrl

Triggered capture sequencer for the ADC sample ring buffer. Sits in the `wb_clk_i` domain between the synchronised ADC sample stream and the write port of the circular capture RAM. It fills a programmable pre-trigger window, waits for a software or level-crossing trigger, records a programmable post-trigger window, then freezes the RAM. It reports the trigger address and window start address so the Wishbone read path can unroll the ring.

## Interface

Parameters:
- `SAMPLE_WIDTH`, 16, sample width in bits; samples are two's complement.
- `PTR_BITS`, 10, RAM address width; ring depth is 2^PTR_BITS.

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, synchronous, active-high.
- `arm`  in  1  one-cycle pulse that starts a capture.
- `abort`  in  1  one-cycle pulse that returns the block to IDLE.
- `sw_trig`  in  1  one-cycle software trigger pulse.
- `trig_en`  in  1  enables the level trigger.
- `trig_rise`  in  1  edge select: 1 = rising crossing, 0 = falling crossing.
- `trig_level`  in  SAMPLE_WIDTH  signed trigger threshold.
- `pre_cnt`  in  PTR_BITS  number of pre-trigger samples.
- `post_cnt`  in  PTR_BITS  number of post-trigger samples, excluding the trigger sample.
- `smp_valid`  in  1  sample strobe, already synchronised to `wb_clk_i`.
- `smp_data`  in  SAMPLE_WIDTH  sample value.
- `ram_we`  out  1  RAM write enable.
- `ram_waddr`  out  PTR_BITS  RAM write address.
- `ram_wdata`  out  SAMPLE_WIDTH  RAM write data.
- `state`  out  3  0=IDLE, 1=FILL, 2=ARMED, 3=POST, 4=DONE.
- `busy`  out  1  high in FILL, ARMED and POST.
- `done`  out  1  high in DONE.
- `cfg_err`  out  1  one-cycle pulse when an arm is rejected.
- `trig_addr`  out  PTR_BITS  RAM address of the trigger sample.
- `start_addr`  out  PTR_BITS  RAM address of the oldest sample in the captured window.

## Operation

- Every output is registered. Reset values: `ram_we`=0, `ram_waddr`=0, `ram_wdata`=0, `state`=IDLE, `busy`=0, `done`=0, `cfg_err`=0, `trig_addr`=0, `start_addr`=0.
- **Arm acceptance.** `arm` is accepted only in IDLE or DONE. In any other state it is ignored.
  - Rejection: if `pre_cnt + post_cnt + 1 > 2^PTR_BITS` (evaluated in PTR_BITS+1 bits), the block pulses `cfg_err` and stays in its current state.
  - On accept: write pointer clears to 0; `pre_cnt` and `post_cnt` are latched; `done` clears; the previous-sample valid flag clears; the next state is FILL, or ARMED if `pre_cnt`=0.
- **Writes.** In FILL, ARMED and POST, each `smp_valid` produces exactly one RAM write. The write pointer increments after each write and wraps from 2^PTR_BITS-1 to 0.
- **FILL.** Counts writes. After the `pre_cnt`-th write the block moves to ARMED. Triggers are ignored in FILL; a `sw_trig` during FILL is dropped.
- **ARMED.** Writes continue and overwrite the oldest samples.
  - `sw_trig` sets a pending flag.
  - On each `smp_valid`, the current sample is the trigger sample if either:
    - the pending flag is set; or
    - `trig_en`=1, the previous sample is valid, and a crossing is detected. Rising crossing: prev < `trig_level` <= cur. Falling crossing: prev >= `trig_level` > cur. All comparisons are signed.
  - On a trigger sample:
    - The sample is written.
    - `trig_addr` takes the sample's write address.
    - `start_addr` = `trig_addr - pre_cnt`, modulo 2^PTR_BITS.
    - The pending flag clears.
    - The next state is POST, or DONE directly if `post_cnt`=0.
- **Previous sample.** The previous-sample register updates on every written sample, including those in FILL.
- **POST.** Writes `post_cnt` further samples, then moves to DONE.
- **DONE.** No writes. Holds `trig_addr`/`start_addr` until the next accepted arm.
- **Abort.** Moves any state to IDLE. `ram_we` is 0 from the following cycle. A sample arriving in the same cycle as `abort` is not written. `abort` with `arm` in the same cycle: abort wins and the arm is dropped. `abort` in IDLE is a no-op.
- **Arm in DONE.** Restarts the capture; the previous capture data is overwritten.

## Timing

- Write pipeline latency is 1 cycle: `smp_valid`/`smp_data` sampled at edge N drive `ram_we`/`ram_wdata`/`ram_waddr` during cycle N+1. `ram_we` is high for exactly one cycle per sample.
- `state`, `busy` and `done` change at the same edge that registers the write causing the transition. On the final POST sample, `done` rises in the same cycle that its `ram_we` is high.
- `trig_addr` and `start_addr` update at the same edge as the trigger sample's `ram_we`.
- `cfg_err` is high the cycle after the rejected `arm`.
- `smp_valid` may be asserted on consecutive cycles; full throughput is 1 sample per clock with no stall.
- `sw_trig` coincident with a `smp_valid` in ARMED makes that same sample the trigger sample.
- A reset asserted mid-capture forces all reset values at the next edge; any write in flight is dropped.

## Test plan

- Reset, then `pre_cnt`=4, `post_cnt`=3, arm, stream 0,1,2,… with `smp_valid` every cycle, `sw_trig` concurrent with sample 10 -> writes at addresses 0..13, `trig_addr`=10, `start_addr`=6, `done` high with the write of sample 13, no writes afterwards.
- Level trigger: `trig_en`=1, `trig_rise`=1, `trig_level`=0x0000, `pre_cnt`=2, stream -3,-2,-1,+1 -> the +1 sample is the trigger, `trig_addr`=3, `start_addr`=1.
  - Repeat with `trig_rise`=0 and the stream +1,0,-1 -> the -1 sample triggers.
- Wraparound: `PTR_BITS`=10, `pre_cnt`=8, `post_cnt`=5, hold in ARMED for 1030 samples, then `sw_trig` -> `trig_addr`=(1030 mod 1024)=6, `start_addr`=1022, final write at address 11.
- Config error: `pre_cnt`=600, `post_cnt`=500, arm -> `cfg_err` pulses for one cycle, state stays IDLE, `ram_we` never asserts.
- Abort during POST, plus abort with arm in the same cycle -> next cycle `state`=IDLE, `ram_we`=0, `done`=0; the simultaneous arm is ignored.
- `sw_trig` during FILL with `pre_cnt`=4 -> no trigger; the block stays ARMED after the 4th sample until a later trigger arrives.
